scie_pipelined: RTL and testbench

SCIE_PIPELINED -- requirements
Module: scie_pipelined

---
 rtl/scie_pkg.sv | 12 +
 rtl/scie_fir_datapath.sv | 53 +++++
 rtl/scie_pipelined.sv | 66 ++++++
 tb/tb_scie_pipelined.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/scie_pkg.sv
// rtl/scie_pkg.sv - shared opcodes and default sizes for the SCIE FIR extension
package scie_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NTAPS = 5;

    localparam logic [6:0] OPC_SET_COEF = 7'h0B;
    localparam logic [6:0] OPC_PUSH     = 7'h2B;
    localparam logic [6:0] OPC_READ     = 7'h5B;
    localparam logic [6:0] OPC_CLEAR    = 7'h7B;

endpackage

// File: rtl/scie_fir_datapath.sv
// rtl/scie_fir_datapath.sv - coefficient store, sample delay line and combinational multiply-accumulate
module scie_fir_datapath
    import scie_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int NTAPS = DEFAULT_NTAPS
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_set_coef,
    input  logic            i_push,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_y
);

    logic [XLEN-1:0] r_coef [NTAPS];
    logic [XLEN-1:0] r_x    [NTAPS];
    logic [XLEN-1:0] w_acc;

    // Coefficient writes; an index matching no tap (rs2 >= NTAPS) leaves every coefficient alone
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NTAPS; i++) r_coef[i] <= '0;
        end else if (i_set_coef) begin
            for (int i = 0; i < NTAPS; i++) begin
                if (i_rs2 == XLEN'(i)) r_coef[i] <= i_rs1;
            end
        end
    end

    // Delay line: push shifts a new sample in at tap 0, clear empties it
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
        end else if (i_push) begin
            r_x[0] <= i_rs1;
            for (int i = 1; i < NTAPS; i++) r_x[i] <= r_x[i-1];
        end
    end

    // Sum of products from the current register state, wrapping modulo 2^XLEN
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < NTAPS; i++) begin
            w_acc = w_acc + r_coef[i] * r_x[i];
        end
    end

    assign o_y = w_acc;

endmodule

// File: rtl/scie_pipelined.sv
// rtl/scie_pipelined.sv - SCIE FIR custom-instruction unit top; SCIE_FIR_CLEAR_EN enables the CLEAR opcode
module scie_pipelined
    import scie_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int NTAPS = DEFAULT_NTAPS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    input  logic [31:0]     io_insn,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    output logic [XLEN-1:0] io_rd
);

    logic [6:0]      w_opcode;
    logic            w_set_coef;
    logic            w_push;
    logic            w_read;
    logic            w_clear;
    logic [XLEN-1:0] w_y;
    logic [XLEN-1:0] r_rd;
    logic            w_unused_insn;

    assign w_opcode      = io_insn[6:0];
    assign w_unused_insn = ^io_insn[31:7];

    // Opcode decode; only valid cycles produce a strobe
    always_comb begin
        w_set_coef = io_valid && (w_opcode == OPC_SET_COEF);
        w_push     = io_valid && (w_opcode == OPC_PUSH);
        w_read     = io_valid && (w_opcode == OPC_READ);
`ifdef SCIE_FIR_CLEAR_EN
        w_clear    = io_valid && (w_opcode == OPC_CLEAR);
`else
        w_clear    = 1'b0;
`endif
    end

    scie_fir_datapath #(
        .XLEN  (XLEN),
        .NTAPS (NTAPS)
    ) u_datapath (
        .i_clk      (clock),
        .i_reset    (reset),
        .i_set_coef (w_set_coef),
        .i_push     (w_push),
        .i_clear    (w_clear),
        .i_rs1      (io_rs1),
        .i_rs2      (io_rs2),
        .o_y        (w_y)
    );

    // Result register: captures the sum on READ and holds otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd <= '0;
        end else if (w_read) begin
            r_rd <= w_y;
        end
    end

    assign io_rd = r_rd;

endmodule

// File: tb/tb_scie_pipelined.sv
// tb/tb_scie_pipelined.sv - directed and randomized checks of scie_pipelined against a behavioural FIR model
module tb_scie_pipelined;

    localparam int XLEN  = 32;
    localparam int NTAPS = 5;

    localparam logic [6:0] OP_SET   = 7'h0B;
    localparam logic [6:0] OP_PUSH  = 7'h2B;
    localparam logic [6:0] OP_READ  = 7'h5B;
    localparam logic [6:0] OP_CLEAR = 7'h7B;
    localparam logic [6:0] OP_NOP   = 7'h13;

    logic            clock = 1'b0;
    logic            reset;
    logic            io_valid;
    logic [31:0]     io_insn;
    logic [XLEN-1:0] io_rs1;
    logic [XLEN-1:0] io_rs2;
    logic [XLEN-1:0] io_rd;

    int vectors     = 0;
    int miscompares = 0;

    logic [XLEN-1:0] m_coef [NTAPS];
    logic [XLEN-1:0] m_x    [NTAPS];
    logic [XLEN-1:0] m_rd;

    scie_pipelined #(.XLEN(XLEN), .NTAPS(NTAPS)) dut (
        .clock    (clock),
        .reset    (reset),
        .io_valid (io_valid),
        .io_insn  (io_insn),
        .io_rs1   (io_rs1),
        .io_rs2   (io_rs2),
        .io_rd    (io_rd)
    );

    always #5 clock = ~clock;

    function automatic logic [XLEN-1:0] model_y();
        logic [XLEN-1:0] acc;
        acc = '0;
        for (int i = 0; i < NTAPS; i++) acc = acc + m_coef[i] * m_x[i];
        return acc;
    endfunction

    task automatic model_apply(input logic rst, input logic vld, input logic [6:0] op,
                               input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                m_coef[i] = '0;
                m_x[i]    = '0;
            end
            m_rd = '0;
        end else if (vld) begin
            if (op == OP_SET) begin
                if (rs2 < NTAPS) m_coef[rs2] = rs1;
            end else if (op == OP_PUSH) begin
                for (int i = NTAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
                m_x[0] = rs1;
            end else if (op == OP_READ) begin
                m_rd = model_y();
            end
`ifdef SCIE_FIR_CLEAR_EN
            else if (op == OP_CLEAR) begin
                for (int i = 0; i < NTAPS; i++) m_x[i] = '0;
            end
`endif
        end
    endtask

    task automatic step(input logic rst, input logic vld, input logic [6:0] op,
                        input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2, input string tag);
        logic [31:0] insn;
        @(negedge clock);
        insn       = $urandom();
        insn[6:0]  = op;
        reset      = rst;
        io_valid   = vld;
        io_insn    = insn;
        io_rs1     = rs1;
        io_rs2     = rs2;
        @(posedge clock);
        #1;
        model_apply(rst, vld, op, rs1, rs2);
        vectors++;
        assert (io_rd === m_rd) else begin
            miscompares++;
            $error("FAIL %s: io_rd observed %0h expected %0h", tag, io_rd, m_rd);
        end
    endtask

    task automatic check_const(input string tag, input logic [XLEN-1:0] exp);
        vectors++;
        assert (io_rd === exp) else begin
            miscompares++;
            $error("FAIL %s: io_rd observed %0h expected %0h", tag, io_rd, exp);
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, OP_NOP, $urandom(), $urandom(), tag);
    endtask

    task automatic load_coefs();
        step(1'b0, 1'b1, OP_SET, 32'd42, 32'd0, "set_c0");
        step(1'b0, 1'b1, OP_SET, 32'd76, 32'd1, "set_c1");
        step(1'b0, 1'b1, OP_SET, 32'd49, 32'd2, "set_c2");
        step(1'b0, 1'b1, OP_SET, 32'd33, 32'd3, "set_c3");
        step(1'b0, 1'b1, OP_SET, 32'd7,  32'd4, "set_c4");
    endtask

    task automatic push_read(input logic [XLEN-1:0] s, input logic [XLEN-1:0] exp, input string tag);
        step(1'b0, 1'b1, OP_PUSH, s, $urandom(), "push");
        idle("idle");
        step(1'b0, 1'b1, OP_READ, $urandom(), $urandom(), "read");
        check_const(tag, exp);
    endtask

    initial begin
        logic       rst;
        logic       vld;
        logic [6:0] op;
        logic [XLEN-1:0] rs2;

        for (int i = 0; i < NTAPS; i++) begin
            m_coef[i] = '0;
            m_x[i]    = '0;
        end
        m_rd     = '0;
        reset    = 1'b1;
        io_valid = 1'b0;
        io_insn  = '0;
        io_rs1   = '0;
        io_rs2   = '0;

        // reset with concurrent instructions that must be ignored
        step(1'b1, 1'b1, OP_SET,  32'd5, 32'd0, "reset_set");
        step(1'b1, 1'b1, OP_PUSH, 32'd9, 32'd0, "reset_push");
        check_const("reset_rd", '0);
        step(1'b0, 1'b1, OP_READ, $urandom(), $urandom(), "read_after_reset");
        check_const("read_after_reset_zero", '0);

        // coefficient load, single sample, then growing history
        load_coefs();
        push_read(32'd15, 32'd630,   "fir_s15");
        push_read(32'd90, 32'd4920,  "fir_s90");
        push_read(32'd59, 32'd10053, "fir_s59");
        push_read(32'd54, 32'd11657, "fir_s54");
        push_read(32'd95, 32'd14060, "fir_s95");

        // out-of-range index and invalid cycles leave everything unchanged
        step(1'b0, 1'b1, OP_SET, 32'd999, 32'd7, "set_oob");
        step(1'b0, 1'b0, OP_SET,  32'd1234, 32'd0, "inv_set");
        step(1'b0, 1'b0, OP_PUSH, 32'd77,   32'd0, "inv_push");
        step(1'b0, 1'b0, OP_READ, 32'd0,    32'd0, "inv_read");
        step(1'b0, 1'b1, OP_READ, $urandom(), $urandom(), "read_unchanged");
        check_const("read_unchanged_val", 32'd14060);

        // reset mid-operation
        step(1'b1, 1'b0, OP_NOP, 32'd0, 32'd0, "mid_reset");
        check_const("mid_reset_rd", '0);
        step(1'b0, 1'b1, OP_READ, $urandom(), $urandom(), "read_post_reset");
        check_const("read_post_reset_zero", '0);

        // wrap-around and back-to-back PUSH then READ
        step(1'b0, 1'b1, OP_SET,  32'hFFFF_FFFF, 32'd0, "set_max");
        step(1'b0, 1'b1, OP_PUSH, 32'd2, $urandom(), "push2");
        step(1'b0, 1'b1, OP_READ, $urandom(), $urandom(), "read_wrap");
        check_const("wrap_val", 32'hFFFF_FFFE);

        // opcode 7'h7B: CLEAR when enabled, otherwise no effect
        step(1'b1, 1'b0, OP_NOP, 32'd0, 32'd0, "reset_clear");
        load_coefs();
        push_read(32'd15, 32'd630, "fir_s15_again");
        step(1'b0, 1'b1, OP_CLEAR, $urandom(), $urandom(), "clear");
        step(1'b0, 1'b1, OP_READ, $urandom(), $urandom(), "read_after_clear");
`ifdef SCIE_FIR_CLEAR_EN
        check_const("clear_zero", '0);
        step(1'b0, 1'b1, OP_PUSH, 32'd1, $urandom(), "push1");
        step(1'b0, 1'b1, OP_READ, $urandom(), $urandom(), "read_after_push1");
        check_const("clear_push1", 32'd42);
`else
        check_const("unknown_7b", 32'd630);
`endif

        // randomized mix against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            vld = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       op = OP_SET;
                1:       op = OP_PUSH;
                2, 3:    op = OP_READ;
                4:       op = OP_CLEAR;
                default: op = 7'($urandom());
            endcase
            rs2 = ($urandom_range(0, 3) == 0) ? 32'($urandom()) : 32'($urandom_range(0, 7));
            step(rst, vld, op, $urandom(), rs2, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
